// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, DE control bundle, and
// the operand-usage decode that the hazard logic relies on.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] BUBBLE_OP = 7'b0000000;

  typedef struct packed {
    logic       valid;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
  } de_ctrl_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_IMM) || (op == OP_OP) || (op == OP_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
  endfunction

endpackage

// File: rtl/rv32i_hazard_detect.sv
// Load-use detector: flags an FD instruction that reads the register a
// load currently in DE will write, which EM forwarding cannot yet supply.
module rv32i_hazard_detect
  import rv32i_pkg::*;
(
  input  logic       de_valid_i,
  input  logic [6:0] de_op_i,
  input  logic [4:0] de_rd_i,
  input  logic       fd_valid_i,
  input  logic [6:0] fd_op_i,
  input  logic [4:0] fd_rs1_i,
  input  logic [4:0] fd_rs2_i,
  output logic       haz_o
);

  logic load_in_de;
  logic rs1_hit;
  logic rs2_hit;

  assign load_in_de = de_valid_i && (de_op_i == OP_LOAD) && (de_rd_i != 5'd0);
  assign rs1_hit    = uses_rs1(fd_op_i) && (fd_rs1_i == de_rd_i);
  assign rs2_hit    = uses_rs2(fd_op_i) && (fd_rs2_i == de_rd_i);
  assign haz_o      = load_in_de && fd_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/rv32i_de_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// flush/memory-stall handling and saturating stall/flush counters.
module rv32i_de_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_stall,
  input  logic             flush,
  input  logic             FD_valid,
  input  logic [6:0]       FD_OP,
  input  logic [2:0]       FD_funct3,
  input  logic             FD_funct7b5,
  input  logic [4:0]       FD_rs1,
  input  logic [4:0]       FD_rs2,
  input  logic [4:0]       FD_rd,
  input  logic             FD_RegWrite,
  input  logic             FD_MemWrite,
  input  logic             FD_MemRead,
  input  logic [XLEN-1:0]  FD_imm,
  input  logic [XLEN-1:0]  FD_PC,
  input  logic [XLEN-1:0]  FD_rs1_data,
  input  logic [XLEN-1:0]  FD_rs2_data,
  output logic             DE_valid,
  output logic [6:0]       DE_OP,
  output logic [2:0]       DE_funct3,
  output logic             DE_funct7b5,
  output logic [4:0]       DE_rs1,
  output logic [4:0]       DE_rs2,
  output logic [4:0]       DE_rd,
  output logic             DE_RegWrite,
  output logic             DE_MemWrite,
  output logic             DE_MemRead,
  output logic [XLEN-1:0]  DE_imm,
  output logic [XLEN-1:0]  DE_PC,
  output logic [XLEN-1:0]  DE_rs1_data,
  output logic [XLEN-1:0]  DE_rs2_data,
  output logic             lu_stall,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  de_ctrl_t               ctrl_q, ctrl_d, fd_ctrl;
  logic     [XLEN-1:0]    imm_q, imm_d, pc_q, pc_d;
  logic     [XLEN-1:0]    rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic     [CNT_W-1:0]   lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
  logic                   haz;
  logic                   take_bubble;

  rv32i_hazard_detect u_hazard (
    .de_valid_i (ctrl_q.valid),
    .de_op_i    (ctrl_q.op),
    .de_rd_i    (ctrl_q.rd),
    .fd_valid_i (FD_valid),
    .fd_op_i    (FD_OP),
    .fd_rs1_i   (FD_rs1),
    .fd_rs2_i   (FD_rs2),
    .haz_o      (haz)
  );

  assign lu_stall = haz && !flush && !mem_stall;

  assign fd_ctrl = '{valid: 1'b1, op: FD_OP, funct3: FD_funct3, funct7b5: FD_funct7b5,
                     rs1: FD_rs1, rs2: FD_rs2, rd: FD_rd, reg_write: FD_RegWrite,
                     mem_write: FD_MemWrite, mem_read: FD_MemRead};

  // Flush outranks mem_stall; an invalid FD slot loads as a bubble.
  assign take_bubble = flush || (!mem_stall && (haz || !FD_valid));

  always_comb begin
    ctrl_d     = ctrl_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (take_bubble) begin
      ctrl_d     = '0;
      imm_d      = '0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
    end else if (!mem_stall) begin
      ctrl_d     = fd_ctrl;
      imm_d      = FD_imm;
      pc_d       = FD_PC;
      rs1_data_d = FD_rs1_data;
      rs2_data_d = FD_rs2_data;
    end
  end

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (lu_stall && (lu_cnt_q != {CNT_W{1'b1}})) lu_cnt_d = lu_cnt_q + 1'b1;
    if (flush && (fl_cnt_q != {CNT_W{1'b1}}))    fl_cnt_d = fl_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      lu_cnt_q   <= '0;
      fl_cnt_q   <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      lu_cnt_q   <= lu_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
    end
  end

  assign DE_valid     = ctrl_q.valid;
  assign DE_OP        = ctrl_q.op;
  assign DE_funct3    = ctrl_q.funct3;
  assign DE_funct7b5  = ctrl_q.funct7b5;
  assign DE_rs1       = ctrl_q.rs1;
  assign DE_rs2       = ctrl_q.rs2;
  assign DE_rd        = ctrl_q.rd;
  assign DE_RegWrite  = ctrl_q.reg_write;
  assign DE_MemWrite  = ctrl_q.mem_write;
  assign DE_MemRead   = ctrl_q.mem_read;
  assign DE_imm       = imm_q;
  assign DE_PC        = pc_q;
  assign DE_rs1_data  = rs1_data_q;
  assign DE_rs2_data  = rs2_data_q;
  assign lu_stall_cnt = lu_cnt_q;
  assign flush_cnt    = fl_cnt_q;

endmodule

// File: tb/tb_rv32i_de_stage.sv
// Directed table-driven bench for the DE pipeline register and its
// load-use stall, flush, memory-stall and counter-saturation behaviour.
module tb_rv32i_de_stage;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] OPR = 7'b0110011;
  localparam logic [6:0] LUI = 7'b0110111;

  logic        clk = 1'b0;
  logic        reset, mem_stall, flush, FD_valid;
  logic [6:0]  FD_OP;
  logic [2:0]  FD_funct3;
  logic        FD_funct7b5;
  logic [4:0]  FD_rs1, FD_rs2, FD_rd;
  logic        FD_RegWrite, FD_MemWrite, FD_MemRead;
  logic [31:0] FD_imm, FD_PC, FD_rs1_data, FD_rs2_data;
  logic        DE_valid;
  logic [6:0]  DE_OP;
  logic [2:0]  DE_funct3;
  logic        DE_funct7b5;
  logic [4:0]  DE_rs1, DE_rs2, DE_rd;
  logic        DE_RegWrite, DE_MemWrite, DE_MemRead;
  logic [31:0] DE_imm, DE_PC, DE_rs1_data, DE_rs2_data;
  logic        lu_stall;
  logic [3:0]  lu_stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_de_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .mem_stall(mem_stall), .flush(flush),
    .FD_valid(FD_valid), .FD_OP(FD_OP), .FD_funct3(FD_funct3), .FD_funct7b5(FD_funct7b5),
    .FD_rs1(FD_rs1), .FD_rs2(FD_rs2), .FD_rd(FD_rd),
    .FD_RegWrite(FD_RegWrite), .FD_MemWrite(FD_MemWrite), .FD_MemRead(FD_MemRead),
    .FD_imm(FD_imm), .FD_PC(FD_PC), .FD_rs1_data(FD_rs1_data), .FD_rs2_data(FD_rs2_data),
    .DE_valid(DE_valid), .DE_OP(DE_OP), .DE_funct3(DE_funct3), .DE_funct7b5(DE_funct7b5),
    .DE_rs1(DE_rs1), .DE_rs2(DE_rs2), .DE_rd(DE_rd),
    .DE_RegWrite(DE_RegWrite), .DE_MemWrite(DE_MemWrite), .DE_MemRead(DE_MemRead),
    .DE_imm(DE_imm), .DE_PC(DE_PC), .DE_rs1_data(DE_rs1_data), .DE_rs2_data(DE_rs2_data),
    .lu_stall(lu_stall), .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic        rst, fl, ms, fv;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
    logic        e_lu, e_v;
    logic [6:0]  e_op;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_pc;
    logic [3:0]  e_lc, e_fc;
  } vec_t;

  function automatic vec_t mk(input logic rst, fl, ms, fv, input logic [6:0] op,
                              input logic [4:0] rs1, rs2, rd, input logic [31:0] pc,
                              input logic e_lu, e_v, input logic [6:0] e_op,
                              input logic [4:0] e_rs1, e_rs2, e_rd, input logic [31:0] e_pc,
                              input logic [3:0] e_lc, e_fc);
    vec_t v;
    v.rst = rst; v.fl = fl; v.ms = ms; v.fv = fv; v.op = op;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.pc = pc;
    v.e_lu = e_lu; v.e_v = e_v; v.e_op = e_op; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    v.e_rd = e_rd; v.e_pc = e_pc; v.e_lc = e_lc; v.e_fc = e_fc;
    return v;
  endfunction

  // {RegWrite, MemWrite, MemRead} as a decoder would produce them
  function automatic logic [2:0] ctl(input logic [6:0] op);
    return {(op == OPR) || (op == LD) || (op == LUI), op == ST, op == LD};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] d;
    reset = v.rst; flush = v.fl; mem_stall = v.ms; FD_valid = v.fv;
    FD_OP = v.op; FD_rs1 = v.rs1; FD_rs2 = v.rs2; FD_rd = v.rd;
    FD_funct3 = v.rd[2:0]; FD_funct7b5 = v.rs2[0];
    {FD_RegWrite, FD_MemWrite, FD_MemRead} = ctl(v.op);
    FD_PC = v.pc; FD_imm = v.pc + 1; FD_rs1_data = v.pc + 2; FD_rs2_data = v.pc + 3;
    @(negedge clk);
    chk({tag, " lu_stall"}, {31'd0, lu_stall}, {31'd0, v.e_lu});
    @(posedge clk); #1;
    d = (v.e_pc == 0) ? 32'd0 : v.e_pc;
    chk({tag, " DE_valid"}, {31'd0, DE_valid}, {31'd0, v.e_v});
    chk({tag, " DE_OP"}, {25'd0, DE_OP}, {25'd0, v.e_op});
    chk({tag, " DE_rs1"}, {27'd0, DE_rs1}, {27'd0, v.e_rs1});
    chk({tag, " DE_rs2"}, {27'd0, DE_rs2}, {27'd0, v.e_rs2});
    chk({tag, " DE_rd"}, {27'd0, DE_rd}, {27'd0, v.e_rd});
    chk({tag, " DE_funct3"}, {29'd0, DE_funct3}, {29'd0, v.e_rd[2:0]});
    chk({tag, " DE_funct7b5"}, {31'd0, DE_funct7b5}, {31'd0, v.e_rs2[0]});
    chk({tag, " DE_ctl"}, {29'd0, DE_RegWrite, DE_MemWrite, DE_MemRead}, {29'd0, ctl(v.e_op)});
    chk({tag, " DE_PC"}, DE_PC, d);
    chk({tag, " DE_imm"}, DE_imm, (d == 0) ? 32'd0 : d + 1);
    chk({tag, " DE_rs1_data"}, DE_rs1_data, (d == 0) ? 32'd0 : d + 2);
    chk({tag, " DE_rs2_data"}, DE_rs2_data, (d == 0) ? 32'd0 : d + 3);
    chk({tag, " lu_stall_cnt"}, {28'd0, lu_stall_cnt}, {28'd0, v.e_lc});
    chk({tag, " flush_cnt"}, {28'd0, flush_cnt}, {28'd0, v.e_fc});
    $display("%s: rst=%0b fl=%0b ms=%0b op=%07b lu=%0b -> DE v=%0b op=%07b rd=%0d pc=%0h lc=%0d fc=%0d",
             tag, v.rst, v.fl, v.ms, v.op, lu_stall, DE_valid, DE_OP, DE_rd, DE_PC,
             lu_stall_cnt, flush_cnt);
  endtask

  vec_t tbl[32];
  vec_t sv;
  int   exp_lc;

  initial begin
    // rst fl ms fv  op  rs1 rs2 rd  pc       lu v  eop rs1 rs2 rd  epc      lc fc
    tbl[0]  = mk(0,0,0,1, OPR, 1,2,5, 32'h100, 0,1, OPR, 1,2,5, 32'h100, 0,0);
    tbl[1]  = mk(1,0,0,1, OPR, 3,4,9, 32'h104, 0,0, 0,   0,0,0, 32'h0,   0,0);
    tbl[2]  = mk(0,0,0,1, LD,  1,0,5, 32'h108, 0,1, LD,  1,0,5, 32'h108, 0,0);
    tbl[3]  = mk(0,0,0,1, OPR, 5,6,7, 32'h10C, 1,0, 0,   0,0,0, 32'h0,   1,0);
    tbl[4]  = mk(0,0,0,1, OPR, 5,6,7, 32'h10C, 0,1, OPR, 5,6,7, 32'h10C, 1,0);
    tbl[5]  = mk(0,0,0,1, LD,  2,0,8, 32'h110, 0,1, LD,  2,0,8, 32'h110, 1,0);
    tbl[6]  = mk(0,0,0,1, ST,  9,8,0, 32'h114, 1,0, 0,   0,0,0, 32'h0,   2,0);
    tbl[7]  = mk(0,0,0,1, ST,  9,8,0, 32'h114, 0,1, ST,  9,8,0, 32'h114, 2,0);
    tbl[8]  = mk(0,0,0,1, LD,  2,0,8, 32'h118, 0,1, LD,  2,0,8, 32'h118, 2,0);
    tbl[9]  = mk(0,0,0,1, LUI, 8,8,8, 32'h11C, 0,1, LUI, 8,8,8, 32'h11C, 2,0);
    tbl[10] = mk(0,0,0,1, LD,  1,0,0, 32'h120, 0,1, LD,  1,0,0, 32'h120, 2,0);
    tbl[11] = mk(0,0,0,1, OPR, 0,0,1, 32'h124, 0,1, OPR, 0,0,1, 32'h124, 2,0);
    tbl[12] = mk(0,0,0,1, LD,  1,0,5, 32'h128, 0,1, LD,  1,0,5, 32'h128, 2,0);
    tbl[13] = mk(0,1,0,1, OPR, 5,6,7, 32'h12C, 0,0, 0,   0,0,0, 32'h0,   2,1);
    tbl[14] = mk(0,0,0,1, LD,  1,0,5, 32'h130, 0,1, LD,  1,0,5, 32'h130, 2,1);
    tbl[15] = mk(0,1,1,1, OPR, 5,6,7, 32'h134, 0,0, 0,   0,0,0, 32'h0,   2,2);
    tbl[16] = mk(0,0,0,1, OPR, 1,2,3, 32'h138, 0,1, OPR, 1,2,3, 32'h138, 2,2);
    tbl[17] = mk(0,0,1,1, OPR, 3,3,4, 32'h13C, 0,1, OPR, 1,2,3, 32'h138, 2,2);
    tbl[18] = mk(0,0,1,1, OPR, 3,3,4, 32'h13C, 0,1, OPR, 1,2,3, 32'h138, 2,2);
    tbl[19] = mk(0,0,1,1, OPR, 3,3,4, 32'h13C, 0,1, OPR, 1,2,3, 32'h138, 2,2);
    tbl[20] = mk(0,0,0,1, OPR, 3,3,4, 32'h13C, 0,1, OPR, 3,3,4, 32'h13C, 2,2);
    tbl[21] = mk(0,0,0,1, LD,  1,0,5, 32'h140, 0,1, LD,  1,0,5, 32'h140, 2,2);
    tbl[22] = mk(0,0,1,1, OPR, 5,6,7, 32'h144, 0,1, LD,  1,0,5, 32'h140, 2,2);
    tbl[23] = mk(0,0,0,1, OPR, 5,6,7, 32'h144, 1,0, 0,   0,0,0, 32'h0,   3,2);
    tbl[24] = mk(0,0,0,1, OPR, 5,6,7, 32'h144, 0,1, OPR, 5,6,7, 32'h144, 3,2);
    tbl[25] = mk(0,0,0,1, LD,  1,0,5, 32'h148, 0,1, LD,  1,0,5, 32'h148, 3,2);
    tbl[26] = mk(0,0,0,1, LD,  5,0,6, 32'h14C, 1,0, 0,   0,0,0, 32'h0,   4,2);
    tbl[27] = mk(0,0,0,1, LD,  5,0,6, 32'h14C, 0,1, LD,  5,0,6, 32'h14C, 4,2);
    tbl[28] = mk(0,0,0,1, LD,  2,0,9, 32'h150, 0,1, LD,  2,0,9, 32'h150, 4,2);
    tbl[29] = mk(0,0,0,1, BR,  1,9,0, 32'h154, 1,0, 0,   0,0,0, 32'h0,   5,2);
    tbl[30] = mk(0,0,0,1, BR,  1,9,0, 32'h154, 0,1, BR,  1,9,0, 32'h154, 5,2);
    tbl[31] = mk(0,0,0,0, OPR, 1,2,3, 32'h158, 0,0, 0,   0,0,0, 32'h0,   5,2);

    reset = 1'b1; flush = 1'b0; mem_stall = 1'b0; FD_valid = 1'b0;
    FD_OP = '0; FD_funct3 = '0; FD_funct7b5 = 1'b0; FD_rs1 = '0; FD_rs2 = '0; FD_rd = '0;
    FD_RegWrite = 1'b0; FD_MemWrite = 1'b0; FD_MemRead = 1'b0;
    FD_imm = '0; FD_PC = '0; FD_rs1_data = '0; FD_rs2_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset DE_valid", {31'd0, DE_valid}, 32'd0);
    chk("reset DE_OP", {25'd0, DE_OP}, 32'd0);
    chk("reset lu_stall", {31'd0, lu_stall}, 32'd0);
    chk("reset lu_stall_cnt", {28'd0, lu_stall_cnt}, 32'd0);
    chk("reset flush_cnt", {28'd0, flush_cnt}, 32'd0);

    for (int i = 0; i < 32; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Twenty load-use events drive the 4-bit counter into saturation.
    exp_lc = 5;
    for (int k = 0; k < 20; k++) begin
      apply(mk(0,0,0,1, LD, 1,0,5, 32'h200, 0,1, LD, 1,0,5, 32'h200, exp_lc[3:0], 2),
            $sformatf("sat%0d load", k));
      exp_lc = (exp_lc < 15) ? exp_lc + 1 : 15;
      apply(mk(0,0,0,1, OPR, 5,6,7, 32'h204, 1,0, 0, 0,0,0, 32'h0, exp_lc[3:0], 2),
            $sformatf("sat%0d stall", k));
      apply(mk(0,0,0,1, OPR, 5,6,7, 32'h204, 0,1, OPR, 5,6,7, 32'h204, exp_lc[3:0], 2),
            $sformatf("sat%0d use", k));
    end

    sv = mk(1,0,0,1, OPR, 1,2,3, 32'h300, 0,0, 0, 0,0,0, 32'h0, 0,0);
    apply(sv, "final reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
